// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the pipeline registers:
// wait-FSM state encoding, the zero register and the ID/EX bubble control word.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control bits a bubble must clear so that it neither writes back nor loads.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
  } idex_ctrl_t;

  localparam idex_ctrl_t BUBBLE_CTRL = '{reg_write: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID operands and the load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_MemRead,
  input  logic       ex_RegWrite,
  input  logic [4:0] ex_write_reg_dest,
  output logic       luh
);

  logic rs_hit;
  logic rt_hit;
  logic load_writes;

  // $0 is never a real producer, so a load targeting it cannot create a hazard.
  assign load_writes = ex_MemRead & ex_RegWrite & (ex_write_reg_dest != REG_ZERO);
  assign rs_hit      = id_uses_rs & (id_rs == ex_write_reg_dest);
  assign rt_hit      = id_uses_rt & (id_rt == ex_write_reg_dest);
  assign luh         = load_writes & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use and branch hazards plus a timed wait FSM
// for multi-cycle data-memory accesses, with a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_MemRead,
  input  logic             ex_RegWrite,
  input  logic [4:0]       ex_write_reg_dest,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  mem_state_t state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       luh;
  logic       memstall;

  hazard_detect u_hazard_detect (
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rs        (id_uses_rs),
    .id_uses_rt        (id_uses_rt),
    .ex_MemRead        (ex_MemRead),
    .ex_RegWrite       (ex_RegWrite),
    .ex_write_reg_dest (ex_write_reg_dest),
    .luh               (luh)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Outputs are zero-latency: they follow the registered state and live inputs.
  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    memstall      = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          memstall  = 1'b1;
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else begin
          memstall = 1'b1;
          if (wcnt == TIMEOUT_CNT) begin
            state_nxt = MEM_ERR;
          end else begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end
      end
      MEM_ERR: begin
        memstall = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase

    // A memory stall freezes every stage, so branch and load-use are re-judged later.
    if (!rst_n) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (memstall) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (luh) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_err = rst_n & (state == MEM_ERR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (pc_stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_write_reg_dest;
  logic       id_uses_rs, id_uses_rt, ex_MemRead, ex_RegWrite;
  logic       ex_branch_taken, mem_req, mem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_bubble, mem_err;
  logic [3:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rs        (id_uses_rs),
    .id_uses_rt        (id_uses_rt),
    .ex_MemRead        (ex_MemRead),
    .ex_RegWrite       (ex_RegWrite),
    .ex_write_reg_dest (ex_write_reg_dest),
    .ex_branch_taken   (ex_branch_taken),
    .mem_req           (mem_req),
    .mem_ready         (mem_ready),
    .pc_stall          (pc_stall),
    .if_id_stall       (if_id_stall),
    .if_id_flush       (if_id_flush),
    .id_ex_stall       (id_ex_stall),
    .id_ex_flush       (id_ex_flush),
    .ex_mem_stall      (ex_mem_stall),
    .mem_wb_bubble     (mem_wb_bubble),
    .mem_err           (mem_err),
    .stall_cycles      (stall_cycles)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, mem_err}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LUH  = 8'b1100_1000;
  localparam logic [7:0] BR   = 8'b0010_1000;
  localparam logic [7:0] MEM  = 8'b1101_0110;
  localparam logic [7:0] ERR  = 8'b1101_0111;
  localparam logic [7:0] RST  = 8'b0010_1010;

  typedef struct {
    logic [7:0] ctrl;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] act;
  assign act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, mem_wb_bubble, mem_err};

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic mr, input logic rw,
                      input logic [4:0] dest, input logic br, input logic req,
                      input logic rdy, input logic [7:0] ctrl, input logic [3:0] cnt,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_MemRead = mr; ex_RegWrite = rw; ex_write_reg_dest = dest;
    ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    e.ctrl = ctrl; e.cnt = cnt; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so each queued vector is checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      if (act !== e.ctrl) begin
        bad++;
        $display("FAIL %s ctrl got=%b expected=%b", e.name, act, e.ctrl);
      end
      total++;
      if (stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL %s stall_cycles got=%0d expected=%0d", e.name, stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    ex_MemRead = 0; ex_RegWrite = 0; ex_write_reg_dest = '0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);

    //   r  rs  rt  urs urt mr rw dest br req rdy  ctrl  cnt  name
    step(0, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   RST,  0,  "reset");
    step(1, 5,  0,  1,  0,  1, 1, 5,   0, 0,  0,   LUH,  0,  "luh_rs");
    step(1, 5,  0,  1,  0,  0, 0, 0,   0, 0,  0,   NONE, 1,  "luh_clear");
    step(1, 0,  0,  1,  0,  1, 1, 0,   0, 0,  0,   NONE, 1,  "dest_zero");
    step(1, 3,  7,  1,  0,  1, 1, 7,   0, 0,  0,   NONE, 1,  "rt_unused");
    step(1, 2,  9,  0,  1,  1, 1, 9,   0, 0,  0,   LUH,  1,  "luh_rt");
    step(1, 5,  0,  1,  0,  1, 1, 5,   1, 0,  0,   BR,   2,  "branch_over_luh");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   NONE, 2,  "idle");
    step(0, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   RST,  2,  "reset2");
    // memory wait: three stalled cycles, released in the ready cycle
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   MEM,  0,  "mem_run_miss");
    step(1, 0,  0,  0,  0,  0, 0, 0,   1, 1,  0,   MEM,  1,  "mem_wait_br");
    step(1, 5,  0,  1,  0,  1, 1, 5,   0, 1,  0,   MEM,  2,  "mem_wait_luh");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  1,   NONE, 3,  "mem_ready");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   NONE, 3,  "mem_after");
    // timeout: one RUN miss, four MEM_WAIT cycles, then terminal MEM_ERR
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   MEM,  3,  "to_run");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   MEM,  4,  "to_w1");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   MEM,  5,  "to_w2");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   MEM,  6,  "to_w3");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   MEM,  7,  "to_w4");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   ERR,  8,  "err_enter");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  1,   ERR,  9,  "err_ready_ignored");
    for (int i = 10; i <= 15; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ERR, 4'(i), "err_hold");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   ERR,  15, "sat_a");
    step(1, 0,  0,  0,  0,  0, 0, 0,   1, 0,  0,   ERR,  15, "sat_b");
    step(0, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   RST,  15, "err_reset");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   NONE, 0,  "err_cleared");
    // reset in the middle of a wait
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   MEM,  0,  "rw_miss");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   MEM,  1,  "rw_wait");
    step(0, 0,  0,  0,  0,  0, 0, 0,   0, 1,  0,   RST,  2,  "rw_reset");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   NONE, 0,  "rw_back_run");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 1,  1,   NONE, 0,  "single_cycle_mem");
    step(1, 0,  0,  0,  0,  0, 0, 0,   0, 0,  0,   NONE, 0,  "final_idle");

    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the five-stage pipeline. It drives the hold and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Detects load-use hazards and taken branches.
- Sequences multi-cycle data-memory accesses through a small wait FSM with a timeout.
- Sits beside the pipeline registers; it reads the ID-stage operand fields, the ID/EX destination/control fields, the EX branch outcome and the data-memory handshake.

Parameters:
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before a fault is declared (range 1..255).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge active
- rst_n  in  1  synchronous active-low reset
- id_rs  in  5  ID-stage source register 1
- id_rt  in  5  ID-stage source register 2
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_MemRead  in  1  instruction in EX is a load
- ex_RegWrite  in  1  instruction in EX writes the register file
- ex_write_reg_dest  in  5  destination of the EX instruction
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  load bubble (RegWrite=0, MemRead=0) into ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_bubble  out  1  load bubble (RegWrite=0) into MEM/WB
- mem_err  out  1  sticky memory-timeout fault
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- State register and encoding:
  - States: RUN=2'd0, MEM_WAIT=2'd1, MEM_ERR=2'd2.
  - Wait counter wcnt is 8-bit.
- Reset (rst_n=0 at a rising edge): state<=RUN, wcnt<=0, stall_cycles<=0.
- Outputs while rst_n=0:
  - if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
  - All stall outputs=0, mem_err=0.
  - Reset mid-MEM_WAIT or in MEM_ERR returns to RUN on that edge.
- Control outputs are combinational from the registered state and the current inputs (zero-latency). stall_cycles and mem_err are registered or state-derived.
- Load-use hazard: luh = ex_MemRead & ex_RegWrite & (ex_write_reg_dest!=0) & ((id_uses_rs & id_rs==ex_write_reg_dest) | (id_uses_rt & id_rt==ex_write_reg_dest)).
- memstall = (state==RUN & mem_req & ~mem_ready) | (state==MEM_WAIT & ~mem_ready) | state==MEM_ERR.
- Output priority, highest first:
  1. memstall: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall =1; mem_wb_bubble=1; no flushes. A branch or load-use hazard under memstall is ignored this cycle and re-evaluated once memstall drops, because the stages hold.
  2. ex_branch_taken: if_id_flush=1, id_ex_flush=1, no stalls. This overrides luh because the ID instruction is wrong-path.
  3. luh: pc_stall=1, if_id_stall=1, id_ex_flush=1. Exactly one bubble per hazard; it clears next cycle once the load moves to MEM.
  4. Otherwise all outputs are 0.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_req & ~mem_ready; wcnt<=1.
  - RUN stays RUN when mem_req & mem_ready (single-cycle access), with no stall.
  - MEM_WAIT -> RUN when mem_ready; the stall drops in the same cycle and wcnt<=0.
  - MEM_WAIT -> MEM_ERR when ~mem_ready & wcnt==MEM_TIMEOUT. Otherwise wcnt<=wcnt+1.
  - MEM_ERR is terminal until reset: mem_err=1 and the full stall is held.
  - mem_req is ignored outside RUN (the EX/MEM register holds it).
- stall_cycles increments when pc_stall=1 and saturates at all-ones.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings RUN, MEM_WAIT and MEM_ERR;
  - REG_ZERO=5'd0;
  - bubble control constant.
- The pipeline registers also use the bubble constant.
- One natural sub-module is hazard_detect, the purely combinational luh compare. The FSM and priority mux stay at top level.

Test Plan:
- Load-use stall: lw writes $5 in EX, ID add reads rs=$5 (uses_rs=1) -> exactly 1 cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1, then all 0; stall_cycles=1.
- Zero-register and unused-operand cases:
  - dest=$0 with rs=$0 -> no stall.
  - rt match with uses_rt=0 -> no stall.
- Branch overrides load-use: ex_branch_taken=1 together with luh=1 -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles -> 3 cycles of full stall plus mem_wb_bubble, state RUN->MEM_WAIT->RUN. Release occurs in the ready cycle and stall_cycles=3.
- Memory timeout: MEM_TIMEOUT=4, mem_ready never asserted -> MEM_ERR after 4 wait cycles, mem_err=1 and stalls held indefinitely. Then rst_n=0 for one edge -> state RUN, mem_err=0, stall_cycles=0.
- Counter saturation and reset during wait:
  - CNT_W=4 with a sustained stall -> stall_cycles saturates at 15.
  - rst_n low mid-MEM_WAIT -> RUN on that edge with flush outputs high.
